fifo_stream_reader: RTL and testbench

Read-side consumer for the team's async FIFO. It lives entirely in the rd_clk domain. It drains the FIFO through its rd_en/empty/rd_data port and presents the words as a valid/ready stream. A burst-framing last flag is asserted every BURST_LEN beats. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so throughput is one word per cycle with no loss under back-pressure.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/skid_buf2.sv | 86 ++++++++
 rtl/fifo_stream_reader.sv | 91 +++++++++
 tb/tb_fifo_stream_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its stream-side adapters.
// Contents: default data width, skid-buffer occupancy state, occupancy helper.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;

    // Encoding equals the number of buffered words.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_state_t;

    function automatic logic [1:0] occ_count(input occ_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer with head/tail pointers and an occupancy FSM.
// Ports: clk, rst_n (async active-low); push/push_data write the tail;
// pop retires the head; clear empties the buffer and dominates push/pop;
// occ is the occupancy state; head_data is the head entry.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output occ_state_t            occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    occ_state_t                 state;
    occ_state_t                 state_nxt;
    logic                       head;
    logic                       head_nxt;
    logic                       tail;
    logic                       tail_nxt;
    logic                       wr_en;
    logic                       do_push;
    logic                       do_pop;
    logic [1:0][DATA_WIDTH-1:0] mem;

    // State and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    // Next-state: push advances, pop retreats, both together hold occupancy
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        wr_en     = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        if (clear) begin
            state_nxt = S_EMPTY;
            head_nxt  = 1'b0;
            tail_nxt  = 1'b0;
        end else begin
            do_push = push && (state != S_TWO);
            do_pop  = pop && (state != S_EMPTY);
            if (do_push) begin
                wr_en    = 1'b1;
                tail_nxt = ~tail;
            end
            if (do_pop) begin
                head_nxt = ~head;
            end
            unique case ({do_push, do_pop})
                2'b10:   state_nxt = (state == S_EMPTY) ? S_ONE : S_TWO;
                2'b01:   state_nxt = (state == S_TWO) ? S_ONE : S_EMPTY;
                default: state_nxt = state;
            endcase
        end
    end

    // Storage entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[tail] <= push_data;
        end
    end

    assign occ       = state;
    assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the async FIFO read port into a valid/ready stream with burst framing.
// Ports: rd_clk, rst_n (async active-low); fifo_empty/fifo_rd_en/fifo_rd_data
// FIFO read side (data one cycle after an accepted read); m_valid/m_ready/
// m_data/m_last stream output; flush drops buffered and in-flight words;
// words_out counts delivered beats modulo 2^CNT_WIDTH.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    occ_state_t        occ;
    logic              in_flight;
    logic              pop;
    logic              push;
    logic              hs_count;
    logic [2:0]        credit_used;
    logic [BEAT_W-1:0] beat_cnt;

    assign pop      = m_valid && m_ready;
    assign push     = in_flight && !flush;
    assign hs_count = pop && !flush;

    // Credit check: buffered + landing - leaving must leave room for one more
    assign credit_used = 3'(occ_count(occ)) + 3'(in_flight);
    assign fifo_rd_en  = rst_n && !fifo_empty && !flush
                         && (credit_used < (3'd2 + 3'(pop)));

    // Read accepted this cycle means data lands next cycle
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= fifo_rd_en;
        end
    end

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .clear     (flush),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid = (occ != S_EMPTY);
    assign m_last  = m_valid && (beat_cnt == BEAT_LAST);

    // Burst beat counter; flush restarts framing
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // Delivered-beat counter, survives flush
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (hs_count) begin
            words_out <= words_out + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO read port,
// table-driven cycle vectors plus hand-written reset and counter-wrap sequences.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic        rd_clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        flush;
    logic [15:0] words_out;

    // Second instance: narrow counter, single-beat bursts
    logic        fifo_empty2;
    logic        fifo_rd_en2;
    logic [7:0]  fifo_rd_data2;
    logic        m_valid2;
    logic        m_ready2;
    logic [7:0]  m_data2;
    logic        m_last2;
    logic        flush2;
    logic [3:0]  words_out2;

    int checks   = 0;
    int failures = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .flush        (flush),
        .words_out    (words_out)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) dut2 (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty2),
        .fifo_rd_en   (fifo_rd_en2),
        .fifo_rd_data (fifo_rd_data2),
        .m_valid      (m_valid2),
        .m_ready      (m_ready2),
        .m_data       (m_data2),
        .m_last       (m_last2),
        .flush        (flush2),
        .words_out    (words_out2)
    );

    // Behavioural FIFO read port: one-cycle read latency
    logic [7:0] fmem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_clr = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_ptr[5:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // A word landing in a full buffer would be lost
    always @(posedge rd_clk) begin
        if (rst_n && !flush && dut.in_flight && dut.occ == S_TWO) begin
            failures++;
            $display("FAIL push_into_full: in_flight=1 occ=S_TWO required never");
        end
    end

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[5:0]] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic fl);
        @(negedge rd_clk);
        m_ready = rdy;
        flush   = fl;
        #1;
    endtask

    typedef struct {
        int          load;
        logic [7:0]  base;
        logic        rdy;
        logic        fl;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        rd_en;
        logic [15:0] words;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int ld, input logic [7:0] b, input logic r,
                                input logic f, input logic v, input logic [7:0] d,
                                input logic l, input logic re, input logic [15:0] w);
        vec_t x;
        x.load = ld; x.base = b; x.rdy = r; x.fl = f; x.valid = v;
        x.data = d; x.last = l; x.rd_en = re; x.words = w;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0;
        fifo_empty2 = 1'b1; fifo_rd_data2 = 8'h5A; m_ready2 = 1'b1; flush2 = 1'b0;

        // Streaming, 8 words, BURST_LEN=4 (beat 0, words 0 at start)
        vt.push_back(mk(8, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h01, 0, 1, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h02, 0, 1, 2));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h03, 1, 1, 3));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h04, 0, 1, 4));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h05, 0, 1, 5));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h06, 0, 0, 6));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h07, 1, 0, 7));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8));
        // Back-pressure: two reads then hold, release after 10 cycles
        vt.push_back(mk(6, 8'h10, 0, 0, 0, 8'h00, 0, 1, 8));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8));
        for (int c = 2; c < 10; c++)
            vt.push_back(mk(0, 8'h00, 0, 0, 1, 8'h10, 0, 0, 8));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h10, 0, 1, 8));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h11, 0, 1, 9));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h12, 0, 1, 10));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h13, 1, 1, 11));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h14, 0, 0, 12));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h15, 0, 0, 13));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 14));
        // Flush in S_TWO with a handshake offered (beat 2 before flush)
        vt.push_back(mk(2, 8'h30, 0, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 8'h30, 0, 0, 14));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 8'h30, 0, 0, 14));
        vt.push_back(mk(0, 8'h00, 1, 1, 1, 8'h30, 0, 0, 14));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 14));
        // Flush with one word buffered and one in flight
        vt.push_back(mk(8, 8'h20, 0, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 1, 1, 1, 8'h20, 0, 0, 14));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h22, 0, 1, 14));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h23, 0, 1, 15));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h24, 0, 1, 16));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h25, 1, 1, 17));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h26, 0, 0, 18));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 8'h27, 0, 0, 19));
        vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 20));

        // Reset values
        @(negedge rd_clk);
        @(negedge rd_clk);
        #1;
        check("rst m_valid", 32'(m_valid), 0);
        check("rst m_data", 32'(m_data), 0);
        check("rst m_last", 32'(m_last), 0);
        check("rst words_out", 32'(words_out), 0);
        check("rst fifo_rd_en", 32'(fifo_rd_en), 0);
        @(negedge rd_clk);
        rst_n = 1'b1;
        step(0, 0);
        check("idle empty rd_en", 32'(fifo_rd_en), 0);

        // Single word, two-cycle latency
        @(negedge rd_clk);
        load(8'hA5, 1);
        m_ready = 1'b1;
        #1;
        check("single c0 rd_en", 32'(fifo_rd_en), 1);
        step(1, 0);
        check("single c1 m_valid", 32'(m_valid), 0);
        step(1, 0);
        check("single c2 m_valid", 32'(m_valid), 1);
        check("single c2 m_data", 32'(m_data), 32'hA5);
        check("single c2 rd_en", 32'(fifo_rd_en), 0);
        step(1, 0);
        check("single c3 words_out", 32'(words_out), 1);
        check("single c3 m_valid", 32'(m_valid), 0);

        // Reset with two words buffered and the FIFO still non-empty
        @(negedge rd_clk);
        load(8'h40, 3);
        m_ready = 1'b0;
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("pre-rst m_valid", 32'(m_valid), 1);
        check("pre-rst m_data", 32'(m_data), 32'h40);
        rst_n = 1'b0;
        #1;
        check("mid-rst m_valid", 32'(m_valid), 0);
        check("mid-rst m_data", 32'(m_data), 0);
        check("mid-rst m_last", 32'(m_last), 0);
        check("mid-rst words_out", 32'(words_out), 0);
        check("mid-rst rd_en", 32'(fifo_rd_en), 0);
        fifo_clr = 1'b1;
        @(negedge rd_clk);
        fifo_clr = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post-rst rd_en", 32'(fifo_rd_en), 0);
        step(0, 0);
        check("post-rst m_valid", 32'(m_valid), 0);
        check("post-rst empty rd_en", 32'(fifo_rd_en), 0);

        // Table-driven cycles
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge rd_clk);
            if (vt[i].load > 0) load(vt[i].base, vt[i].load);
            m_ready = vt[i].rdy;
            flush   = vt[i].fl;
            #1;
            check($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(vt[i].valid));
            if (vt[i].valid)
                check($sformatf("row%0d m_data", i), 32'(m_data), 32'(vt[i].data));
            check($sformatf("row%0d m_last", i), 32'(m_last), 32'(vt[i].last));
            check($sformatf("row%0d fifo_rd_en", i), 32'(fifo_rd_en), 32'(vt[i].rd_en));
            check($sformatf("row%0d words_out", i), 32'(words_out), 32'(vt[i].words));
        end
        flush = 1'b0;
        m_ready = 1'b0;

        // Counter wrap on the 4-bit instance: 17 handshakes
        for (int c = 0; c <= 19; c++) begin
            @(negedge rd_clk);
            fifo_empty2 = (c >= 17);
            #1;
            if (c == 2) begin
                check("wrap c2 m_valid2", 32'(m_valid2), 1);
                check("wrap c2 m_last2", 32'(m_last2), 1);
                check("wrap c2 m_data2", 32'(m_data2), 32'h5A);
            end
            if (c == 17) check("wrap c17 rd_en2", 32'(fifo_rd_en2), 0);
            if (c == 18) check("wrap c18 words_out2", 32'(words_out2), 0);
            if (c == 19) begin
                check("wrap c19 words_out2", 32'(words_out2), 1);
                check("wrap c19 m_valid2", 32'(m_valid2), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
